// File: rtl/sd_prio_sched.sv
// sd_prio_sched: computes the priority and eligibility mask for a priority
// round-robin srdy/drdy mux. It combines a static base priority, an age-based
// boost (so a waiting requester cannot starve) and a token-bucket rate limiter
// per requester. All outputs are registered so the mux never sees a
// combinational path back to its own request/transfer lines.
`timescale 1ns/1ps
module sd_prio_sched #(
    parameter int inputs       = 2,
    parameter int prio_width   = 4,
    parameter int age_width    = 8,
    parameter int credit_width = 6,
    parameter int period_width = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           cfg_enable,
    input  logic [prio_width*inputs-1:0]   cfg_base_prio,
    input  logic [age_width-1:0]           cfg_age_thresh,
    input  logic [credit_width*inputs-1:0] cfg_credit_max,
    input  logic [period_width-1:0]        cfg_refill_period,
    input  logic [inputs-1:0]              c_srdy,
    input  logic [inputs-1:0]              c_xfer,
    output logic [prio_width*inputs-1:0]   prio,
    output logic [inputs-1:0]              mask,
    output logic [inputs-1:0]              starve,
    output logic                           err
);

    localparam logic [prio_width-1:0] PMAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [credit_width-1:0] credit     [inputs];
    logic [credit_width-1:0] credit_nxt [inputs];
    logic [age_width-1:0]    age        [inputs];
    logic [age_width-1:0]    age_nxt    [inputs];
    logic [prio_width-1:0]   boost      [inputs];
    logic [prio_width-1:0]   boost_nxt  [inputs];
    logic [period_width-1:0] timer, timer_nxt;

    logic [prio_width*inputs-1:0] prio_nxt;
    logic [inputs-1:0]            mask_nxt;
    logic [inputs-1:0]            starve_nxt;
    logic                         err_nxt;

    // Per-iteration scratch values for the scheduling loop.
    logic                    tick;
    logic [credit_width-1:0] cmax_v;
    logic [credit_width-1:0] cred_v;
    logic [age_width-1:0]    age_inc;
    logic [prio_width-1:0]   prio_v;

    // Base + boost, evaluated one bit wider so an overflow saturates at PMAX
    // instead of wrapping back to a low priority.
    function automatic logic [prio_width-1:0] sat_add_prio(
        input logic [prio_width-1:0] a,
        input logic [prio_width-1:0] b
    );
        logic [prio_width:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[prio_width] ? PMAX : sum[prio_width-1:0];
    endfunction

    // Boost increment that sticks at PMAX.
    function automatic logic [prio_width-1:0] sat_inc_boost(
        input logic [prio_width-1:0] b
    );
        return (b == PMAX) ? PMAX : b + 1'b1;
    endfunction

    // Next-state and next-output computation; registered outputs are derived
    // from the next counter values so a last-credit transfer drops mask on
    // the very next cycle.
    always_comb begin
        state_nxt  = state;
        timer_nxt  = '0;
        err_nxt    = err;
        prio_nxt   = cfg_base_prio;
        mask_nxt   = '1;
        starve_nxt = '0;
        tick       = 1'b0;
        cmax_v     = '0;
        cred_v     = '0;
        age_inc    = '0;
        prio_v     = '0;
        for (int i = 0; i < inputs; i++) begin
            credit_nxt[i] = '0;
            age_nxt[i]    = '0;
            boost_nxt[i]  = '0;
        end

        case (state)
            S_IDLE: begin
                if (cfg_enable) state_nxt = S_INIT;
            end

            S_INIT: begin
                // Buckets start full; aging and the refill timer start clean.
                for (int i = 0; i < inputs; i++) begin
                    credit_nxt[i] = cfg_credit_max[i*credit_width +: credit_width];
                end
                state_nxt = cfg_enable ? S_RUN : S_IDLE;
            end

            S_RUN: begin
                if (!cfg_enable) begin
                    // Leaving RUN clears every counter (defaults above).
                    state_nxt = S_IDLE;
                end else begin
                    tick      = (timer == cfg_refill_period);
                    timer_nxt = tick ? '0 : timer + 1'b1;

                    for (int i = 0; i < inputs; i++) begin
                        // Token bucket: a zero depth means the input is never limited.
                        cmax_v = cfg_credit_max[i*credit_width +: credit_width];
                        cred_v = credit[i];
                        if (cmax_v != '0) begin
                            if (tick && !c_xfer[i]) begin
                                if (cred_v < cmax_v) cred_v = cred_v + 1'b1;
                            end else if (c_xfer[i] && !tick) begin
                                if (cred_v == '0) err_nxt = 1'b1;
                                else              cred_v  = cred_v - 1'b1;
                            end
                            // A lowered depth takes effect immediately.
                            if (cred_v > cmax_v) cred_v = cmax_v;
                            credit_nxt[i] = cred_v;
                        end

                        // Aging runs regardless of mask, so a throttled input still
                        // climbs in priority while it waits.
                        if ((cfg_age_thresh != '0) && c_srdy[i] && !c_xfer[i]) begin
                            age_inc = age[i] + 1'b1;
                            if (age_inc == cfg_age_thresh) begin
                                age_nxt[i]   = '0;
                                boost_nxt[i] = sat_inc_boost(boost[i]);
                            end else begin
                                age_nxt[i]   = age_inc;
                                boost_nxt[i] = boost[i];
                            end
                        end

                        prio_v = sat_add_prio(cfg_base_prio[i*prio_width +: prio_width],
                                              boost_nxt[i]);
                        prio_nxt[i*prio_width +: prio_width] = prio_v;
                        mask_nxt[i]   = (cmax_v == '0) || (credit_nxt[i] != '0);
                        starve_nxt[i] = (prio_v == PMAX) && c_srdy[i] && !c_xfer[i];
                    end
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters and output registers; reset returns everything to zero at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            timer  <= '0;
            prio   <= '0;
            mask   <= '0;
            starve <= '0;
            err    <= 1'b0;
            for (int i = 0; i < inputs; i++) begin
                credit[i] <= '0;
                age[i]    <= '0;
                boost[i]  <= '0;
            end
        end else begin
            state  <= state_nxt;
            timer  <= timer_nxt;
            prio   <= prio_nxt;
            mask   <= mask_nxt;
            starve <= starve_nxt;
            err    <= err_nxt;
            for (int i = 0; i < inputs; i++) begin
                credit[i] <= credit_nxt[i];
                age[i]    <= age_nxt[i];
                boost[i]  <= boost_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_sd_prio_sched.sv
// Testbench for sd_prio_sched: directed scenarios followed by randomized
// traffic, all compared against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_sd_prio_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_enable;
    logic [7:0]  cfg_base_prio;
    logic [7:0]  cfg_age_thresh;
    logic [11:0] cfg_credit_max;
    logic [15:0] cfg_refill_period;
    logic [1:0]  c_srdy;
    logic [1:0]  c_xfer;
    logic [7:0]  prio;
    logic [1:0]  mask;
    logic [1:0]  starve;
    logic        err;

    int checks   = 0;
    int failures = 0;

    // Model state: mode 0 = idle, 1 = init, 2 = run.
    int m_st;
    int m_cred[2], m_age[2], m_boost[2];
    int m_tmr, m_err;
    int m_prio[2], m_mask[2], m_starve[2];

    always #5 clk = ~clk;

    sd_prio_sched dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cfg_enable       (cfg_enable),
        .cfg_base_prio    (cfg_base_prio),
        .cfg_age_thresh   (cfg_age_thresh),
        .cfg_credit_max   (cfg_credit_max),
        .cfg_refill_period(cfg_refill_period),
        .c_srdy           (c_srdy),
        .c_xfer           (c_xfer),
        .prio             (prio),
        .mask             (mask),
        .starve           (starve),
        .err              (err)
    );

    function automatic int bp(input int i);
        return int'(cfg_base_prio[4*i +: 4]);
    endfunction

    function automatic int cmax(input int i);
        return int'(cfg_credit_max[6*i +: 6]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_tmr = 0; m_err = 0;
        for (int i = 0; i < 2; i++) begin
            m_cred[i] = 0; m_age[i] = 0; m_boost[i] = 0;
            m_prio[i] = 0; m_mask[i] = 0; m_starve[i] = 0;
        end
    endtask

    task automatic idle_view();
        for (int i = 0; i < 2; i++) begin
            m_prio[i] = bp(i); m_mask[i] = 1; m_starve[i] = 0;
        end
    endtask

    task automatic clear_counts();
        m_tmr = 0;
        for (int i = 0; i < 2; i++) begin
            m_cred[i] = 0; m_age[i] = 0; m_boost[i] = 0;
        end
    endtask

    // One clock edge of the scheduler's rules, using the inputs present at the edge.
    task automatic model_edge();
        int en, per, thr, tick, s, x, cm, p;
        en  = int'(cfg_enable);
        per = int'(cfg_refill_period);
        thr = int'(cfg_age_thresh);
        if (m_st == 0) begin
            clear_counts(); idle_view();
            m_st = en ? 1 : 0;
        end else if (m_st == 1) begin
            clear_counts();
            for (int i = 0; i < 2; i++) m_cred[i] = cmax(i);
            idle_view();
            m_st = en ? 2 : 0;
        end else if (en == 0) begin
            clear_counts(); idle_view();
            m_st = 0;
        end else begin
            tick  = (m_tmr == per) ? 1 : 0;
            m_tmr = tick ? 0 : m_tmr + 1;
            for (int i = 0; i < 2; i++) begin
                s  = int'(c_srdy[i]);
                x  = int'(c_xfer[i]);
                cm = cmax(i);
                if (cm == 0) m_cred[i] = 0;
                else begin
                    if (tick && !x) m_cred[i] = (m_cred[i] + 1 > cm) ? cm : m_cred[i] + 1;
                    else if (x && !tick) begin
                        if (m_cred[i] == 0) m_err = 1;
                        else m_cred[i] = m_cred[i] - 1;
                    end
                    if (m_cred[i] > cm) m_cred[i] = cm;
                end
                if (thr == 0 || !s || x) begin
                    m_age[i] = 0; m_boost[i] = 0;
                end else begin
                    m_age[i] = (m_age[i] + 1) % 256;
                    if (m_age[i] == thr) begin
                        m_age[i] = 0;
                        m_boost[i] = (m_boost[i] >= 15) ? 15 : m_boost[i] + 1;
                    end
                end
                p = bp(i) + m_boost[i];
                m_prio[i]   = (p > 15) ? 15 : p;
                m_mask[i]   = (cm == 0 || m_cred[i] != 0) ? 1 : 0;
                m_starve[i] = (m_prio[i] == 15 && s && !x) ? 1 : 0;
            end
        end
    endtask

    task automatic check(input string tag);
        logic [7:0] ep;
        logic [1:0] em, es;
        for (int i = 0; i < 2; i++) begin
            ep[4*i +: 4] = 4'(m_prio[i]);
            em[i] = (m_mask[i] != 0);
            es[i] = (m_starve[i] != 0);
        end
        chk({tag, ".prio"},   32'(prio),   32'(ep));
        chk({tag, ".mask"},   32'(mask),   32'(em));
        chk({tag, ".starve"}, 32'(starve), 32'(es));
        chk({tag, ".err"},    32'(err),    32'(m_err != 0));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    task automatic go_idle();
        cfg_enable = 1'b0; c_srdy = '0; c_xfer = '0;
        step("to_idle");
        step("to_idle");
    endtask

    task automatic async_reset(input string tag);
        reset_n = 1'b0;
        #1;
        model_reset();
        check(tag);
        chk({tag, ".zero"}, 32'({prio, mask, starve, err}), 32'd0);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; cfg_enable = 1'b0; cfg_base_prio = 8'h00;
        cfg_age_thresh = 8'd0; cfg_credit_max = 12'd0; cfg_refill_period = 16'd0;
        c_srdy = '0; c_xfer = '0;
        model_reset();
        @(posedge clk); #1;
        check("reset");
        reset_n = 1'b1;

        // T1: async reset while running, then pass-through in IDLE.
        cfg_base_prio = {4'd7, 4'd2}; cfg_age_thresh = 8'd2; c_srdy = 2'b11;
        cfg_enable = 1'b1;
        repeat (6) step("t1_run");
        async_reset("t1_async");
        cfg_enable = 1'b0; cfg_base_prio = {4'd5, 4'd3}; c_srdy = '0;
        step("t1_idle");
        chk("t1_prio", 32'(prio), 32'h53);
        chk("t1_mask", 32'(mask), 32'h3);

        // T2: rate limit on input 0 only; the mux transfers whenever eligible.
        go_idle();
        cfg_base_prio = 8'h00; cfg_credit_max = {6'd0, 6'd2};
        cfg_refill_period = 16'd9; cfg_age_thresh = 8'd0;
        c_srdy = 2'b11; cfg_enable = 1'b1;
        for (int n = 0; n < 40; n++) begin
            c_xfer = {1'b0, m_mask[0] != 0};
            step("t2");
            chk("t2_mask1", 32'(mask[1]), 32'd1);
        end

        // T3: aging of a never-served requester up to PMAX.
        go_idle();
        cfg_base_prio = {4'd4, 4'd1}; cfg_age_thresh = 8'd3;
        cfg_credit_max = 12'd0; cfg_refill_period = 16'd0;
        cfg_enable = 1'b1; c_srdy = 2'b01; c_xfer = 2'b00;
        step("t3_init"); step("t3_init");
        repeat (3) step("t3_age");
        chk("t3_prio_2", 32'(prio[3:0]), 32'd2);
        repeat (39) step("t3_age");
        chk("t3_prio_15", 32'(prio[3:0]), 32'd15);
        chk("t3_starve", 32'(starve[0]), 32'd1);
        c_xfer = 2'b01;
        step("t3_xfer");
        chk("t3_prio_back", 32'(prio[3:0]), 32'd1);
        chk("t3_starve_clr", 32'(starve[0]), 32'd0);

        // T4: tick and transfer together at a full bucket, then underflow.
        go_idle();
        cfg_base_prio = 8'h00; cfg_age_thresh = 8'd0;
        cfg_credit_max = {6'd0, 6'd4}; cfg_refill_period = 16'd3;
        cfg_enable = 1'b1;
        repeat (12) step("t4_fill");
        c_srdy = 2'b01;
        for (int n = 0; n < 8; n++) begin
            if (m_tmr == 3) break;
            step("t4_align");
        end
        c_xfer = 2'b01;
        step("t4_tickx");
        chk("t4_mask_full", 32'(mask[0]), 32'd1);
        cfg_refill_period = 16'd200;
        repeat (5) step("t4_drain");
        chk("t4_err_set", 32'(err), 32'd1);
        c_xfer = 2'b00;
        repeat (5) step("t4_hold");
        chk("t4_err_sticky", 32'(err), 32'd1);

        // T5: a one-cycle enable drop restarts through IDLE and INIT.
        cfg_base_prio = {4'd4, 4'd1}; cfg_age_thresh = 8'd2;
        cfg_credit_max = {6'd0, 6'd3}; cfg_refill_period = 16'd5;
        c_srdy = 2'b01; c_xfer = 2'b00;
        repeat (15) step("t5_run");
        cfg_enable = 1'b0;
        step("t5_off");
        chk("t5_idle_prio", 32'(prio), 32'h41);
        cfg_enable = 1'b1;
        repeat (3) step("t5_restart");
        chk("t5_boost_clr", 32'(prio[3:0]), 32'd1);
        chk("t5_reload", 32'(mask[0]), 32'd1);

        // T6: base 14 with threshold 1 saturates at 15.
        go_idle();
        cfg_base_prio = {4'd0, 4'd14}; cfg_age_thresh = 8'd1; cfg_credit_max = 12'd0;
        cfg_enable = 1'b1; c_srdy = 2'b01;
        repeat (3) step("t6_start");
        for (int n = 0; n < 5; n++) begin
            step("t6_hold");
            chk("t6_prio_sat", 32'(prio[3:0]), 32'd15);
        end

        // Randomized traffic and configuration changes.
        for (int n = 0; n < 700; n++) begin
            if ($urandom_range(0, 59) == 0) cfg_enable = ~cfg_enable;
            if ($urandom_range(0, 79) == 0) begin
                cfg_enable = 1'b0;
                cfg_refill_period = 16'($urandom_range(0, 5));
            end
            if ($urandom_range(0, 29) == 0) begin
                cfg_base_prio  = 8'($urandom);
                cfg_age_thresh = 8'($urandom_range(0, 4));
                cfg_credit_max = {6'($urandom_range(0, 5)), 6'($urandom_range(0, 5))};
            end
            c_srdy = 2'($urandom);
            c_xfer = c_srdy & 2'($urandom);
            if ($urandom_range(0, 249) == 0) async_reset("rnd_rst");
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
